// File: rtl/rx_frame_ctrl.sv
// Asynchronous serial receiver: start validation, mid-bit sampling, stop check and a one-word output handshake.
// Optional even-parity bit is enabled by defining RX_PARITY_EN.
module rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_ready,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d, shift_in;
    logic                  prev_in_q;
    logic                  ev_good_q, ev_good_d;
    logic                  ev_ferr_q, ev_ferr_d;
    logic                  ev_perr_q, ev_perr_d;
    logic [DATA_BITS-1:0]  data_out_q, data_out_d;
    logic                  data_ready_q, data_ready_d;
    logic                  busy_q;
    logic                  ferr_q, ferr_d;
    logic                  perr_q, perr_d;
    logic                  ovr_q, ovr_d;
    logic                  start_edge;
    logic                  sample_half, sample_full;
    logic                  par_bad;

    // New bit enters at the MSB so the first received bit ends up in the LSB.
    generate
        if (DATA_BITS == 1) begin : g_shift_one
            assign shift_in = serial_in;
        end else begin : g_shift_many
            assign shift_in = {serial_in, shift_q[DATA_BITS-1:1]};
        end
    endgenerate

`ifdef RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    assign sample_half = (tmr_q == HALF_LAST);
    assign sample_full = (tmr_q == FULL_LAST);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        start_edge = 1'b0;
        ev_good_d  = 1'b0;
        ev_ferr_d  = 1'b0;
        ev_perr_d  = 1'b0;
`ifdef RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!serial_in && prev_in_q) begin
                    state_d    = S_START;
                    start_edge = 1'b1;
`ifdef RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            S_START: begin
                if (sample_half) state_d = serial_in ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample_full) begin
                    shift_d = shift_in;
                    if (bit_cnt_q == BIT_LAST) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (sample_full) begin
                    par_bad_d = (serial_in != ^shift_q);
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_full) begin
                    ev_perr_d = par_bad;
                    if (serial_in) begin
                        ev_good_d = !par_bad;
                        state_d   = S_IDLE;
                    end else begin
                        ev_ferr_d = 1'b1;
                        state_d   = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (serial_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counters restart on every state change; the timer also wraps at each data sample.
    always_comb begin
        tmr_d     = '0;
        bit_cnt_d = bit_cnt_q;
        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end else if (state_q != S_IDLE && state_q != S_WAIT_IDLE) begin
            tmr_d = sample_full ? '0 : tmr_q + TW'(1);
            if (state_q == S_DATA && sample_full) bit_cnt_d = bit_cnt_q + BW'(1);
        end
    end

    // Frame results are applied one cycle after the stop sample.
    always_comb begin
        data_out_d   = data_out_q;
        data_ready_d = data_ready_q;
        ovr_d        = ovr_q;
        ferr_d       = ferr_q;
        perr_d       = perr_q;
        if (data_read) begin
            data_ready_d = 1'b0;
            ovr_d        = 1'b0;
        end
        if (ev_good_q) begin
            data_out_d   = shift_q;
            data_ready_d = 1'b1;
            if (data_ready_q && !data_read) ovr_d = 1'b1;
        end
        if (start_edge) begin
            ferr_d = 1'b0;
            perr_d = 1'b0;
        end
        if (ev_ferr_q) ferr_d = 1'b1;
        if (ev_perr_q) perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            tmr_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            prev_in_q    <= 1'b1;
            ev_good_q    <= 1'b0;
            ev_ferr_q    <= 1'b0;
            ev_perr_q    <= 1'b0;
            data_out_q   <= '0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            ovr_q        <= 1'b0;
`ifdef RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            prev_in_q    <= serial_in;
            ev_good_q    <= ev_good_d;
            ev_ferr_q    <= ev_ferr_d;
            ev_perr_q    <= ev_perr_d;
            data_out_q   <= data_out_d;
            data_ready_q <= data_ready_d;
            busy_q       <= (state_q != S_IDLE);
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            ovr_q        <= ovr_d;
`ifdef RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    assign data_out      = data_out_q;
    assign data_ready    = data_ready_q;
    assign busy          = busy_q;
    assign framing_error = ferr_q;
    assign parity_error  = perr_q;
    assign overrun_error = ovr_q;

endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Serial receive frame controller that sequences bit-timing and bit-count counters to deserialize an asynchronous, LSB-first serial stream into parallel words. It sits between the synchronized serial input pin and the downstream word consumer. It owns start-bit validation, mid-bit sampling, stop-bit checking and a one-word output handshake.

## Interface
- CLKS_PER_BIT, 10, clk cycles per serial bit; legal range 4..65535
- DATA_BITS, 8, data bits per frame; legal range 1..16
- clk  input  1  rising-edge clock
- n_rst  input  1  asynchronous, active-low reset
- serial_in  input  1  serial line, already synchronized to clk; idle high
- data_read  input  1  consumer acknowledge; clears data_ready
- data_out  output  DATA_BITS  last good received word
- data_ready  output  1  data_out holds an unread word
- busy  output  1  frame in progress (state ≠ IDLE)
- framing_error  output  1  sticky; last stop bit sampled 0
- parity_error  output  1  sticky; last parity bit mismatched (see Configuration)
- overrun_error  output  1  sticky; a good word arrived while data_ready=1

## Operation
- Internal datapath:
  - Bit-timer counter, width $clog2(CLKS_PER_BIT+1).
  - Bit counter, width $clog2(DATA_BITS+1).
  - DATA_BITS shift register.
  - prev_in register, reset value 1.
  - Both counters clear synchronously on any state change.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
- IDLE:
  - Call the edge at which serial_in=0 and prev_in=1 E0.
  - At E0: go to START, clear framing_error and parity_error.
- START:
  - Sample at E0+CLKS_PER_BIT/2 (floor).
  - If 0: go to DATA. If 1: false start, go to IDLE, no flags change.
- DATA:
  - Sample every CLKS_PER_BIT cycles. Shift right, new bit into the MSB, so the first bit lands in the LSB.
  - After DATA_BITS samples: go to PARITY (if enabled), otherwise STOP.
- STOP, one CLKS_PER_BIT later:
  - If sample is 1 and no parity error: load data_out, set data_ready, go to IDLE.
  - If sample is 0: set framing_error, leave data_out and data_ready unchanged, go to WAIT_IDLE.
- WAIT_IDLE: go to IDLE on the first edge where serial_in=1.
- Overrun:
  - A good word arriving while data_ready=1 and data_read=0 sets overrun_error and overwrites data_out.
  - overrun_error clears only on reset or on a data_read edge.
- data_read:
  - Clears data_ready at the next edge.
  - If data_read is asserted on the same edge a good word loads: data_ready stays 1, no overrun.
- Reset (asynchronous, any time, mid-frame included):
  - State goes to IDLE; counters, shift register and data_out go to 0.
  - data_ready, busy and all error flags go to 0.
  - The partial frame is discarded.

## Timing
- Sample points, with defaults (10/8):
  - Start: E0+CLKS_PER_BIT/2, i.e. E0+5.
  - Data bit k (k=0..DATA_BITS-1): E0+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT, i.e. E0+15..E0+85.
  - Stop: E0+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT, i.e. E0+95. Add CLKS_PER_BIT when parity is enabled.
- Outputs are registered:
  - data_out, data_ready and the error flags change at the edge after the stop sample (E0+96 with defaults).
  - busy rises at E0+1. It falls at the same edge data_ready rises, or at exit from WAIT_IDLE.
- A new start edge is accepted from the first IDLE cycle onward. Back-to-back frames with a one-bit stop are supported with no dead time.
- All boundary conditions are cycle-exact; no input is ignored for more than zero cycles outside the states listed.

## Configuration
- RX_PARITY_EN:
  - Defined:
    - Adds the PARITY state: one extra bit, even parity over the data bits, sampled CLKS_PER_BIT after the last data bit.
    - Mismatch sets parity_error and suppresses the load: data_out and data_ready are unchanged.
    - The frame still proceeds to STOP; a good stop bit returns to IDLE.
  - Undefined:
    - There is no PARITY state and STOP follows DATA directly.
    - parity_error is tied to 0.

## Test plan
- Reset mid-frame: drive 0 on serial_in, assert n_rst low at E0+40 → all outputs 0 immediately, state IDLE; line released high → no data_ready.
- Good frame 0xA5, defaults: data_out=0xA5 and data_ready=1 at E0+96; busy low the same edge; data_read pulse → data_ready=0 next edge.
- False start: 3-cycle low glitch → no transition out of START beyond E0+5, busy falls, no flags, data_ready stays 0.
- Framing error: frame 0x3C with stop=0 → framing_error=1, data_out unchanged; line held low 20 cycles → busy stays 1 until line goes high; next good frame clears framing_error.
- Overrun: two back-to-back frames 0x11 then 0x22, no data_read → data_out=0x22, overrun_error=1; repeat with data_read on the load edge → overrun_error=0.
- RX_PARITY_EN: 0x07 with parity bit 1 → data_ready at E0+106; with parity 0 → parity_error=1 and data_ready unchanged.
